// File: rtl/mpmc10_state_hist.sv
// rtl/mpmc10_state_hist.sv - state-history tracker beside the mpmc10 controller FSM
// Optional stuck-state watchdog compiled in with `define MPMC10_STATE_HIST_TIMEOUT_EN.
module mpmc10_state_hist #(
  parameter int W         = 4,
  parameter int DEPTH     = 4,
  parameter int IDLE_CODE = 0,
  parameter int CW        = 8,
  parameter int TIMEOUT   = 200,
  parameter int TCW       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [W-1:0]         state,
  input  logic                 clr_timeout,
  output logic [W-1:0]         prev_state,
  output logic [W-1:0]         cur_state,
  output logic [DEPTH*W-1:0]   hist,
  output logic                 changed,
  output logic [CW-1:0]        dwell,
  output logic [TCW-1:0]       trans_cnt,
  output logic                 timeout,
  output logic [W-1:0]         timeout_state
);

  localparam logic [W-1:0]  IDLE      = W'(IDLE_CODE);
  localparam logic [CW-1:0] DWELL_MAX = '1;

  logic               trans;
  logic               state_idle;
  logic [DEPTH*W-1:0] hist_next;

  assign trans      = (state != cur_state);
  assign state_idle = (state == IDLE);

  // Entry 0 takes the state being left; older entries move one slot down.
  always_comb begin
    hist_next = hist;
    hist_next[0 +: W] = cur_state;
    for (int i = 1; i < DEPTH; i++) begin
      hist_next[i*W +: W] = hist[(i-1)*W +: W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_state <= IDLE;
      cur_state  <= IDLE;
      hist       <= {DEPTH{IDLE}};
      changed    <= 1'b0;
      dwell      <= '0;
      trans_cnt  <= '0;
    end else begin
      cur_state <= state;
      // Legacy previous-state rule: idle forces, any other new value is taken.
      if (state_idle) begin
        prev_state <= IDLE;
      end else if (state != prev_state) begin
        prev_state <= state;
      end

      if (trans) begin
        hist      <= hist_next;
        changed   <= 1'b1;
        trans_cnt <= trans_cnt + TCW'(1);
        dwell     <= '0;
      end else begin
        changed <= 1'b0;
        if (state_idle) begin
          dwell <= '0;
        end else if (dwell != DWELL_MAX) begin
          dwell <= dwell + CW'(1);
        end
      end
    end
  end

`ifdef MPMC10_STATE_HIST_TIMEOUT_EN
  localparam logic [CW-1:0] TRIP = CW'(TIMEOUT - 1);

  logic wd_set;

  assign wd_set = (cur_state != IDLE) && !trans && (dwell == TRIP);

  // Set beats clear; the captured state is frozen while the flag stays up.
  always_ff @(posedge clk) begin
    if (rst) begin
      timeout       <= 1'b0;
      timeout_state <= IDLE;
    end else if (wd_set) begin
      timeout <= 1'b1;
      if (!timeout || clr_timeout) begin
        timeout_state <= cur_state;
      end
    end else if (clr_timeout) begin
      timeout <= 1'b0;
    end
  end
`else
  logic unused_clr;

  assign unused_clr    = clr_timeout;
  assign timeout       = 1'b0;
  assign timeout_state = IDLE;
`endif

endmodule

// File: tb/tb_mpmc10_state_hist.sv
// tb/tb_mpmc10_state_hist.sv - self-checking bench for mpmc10_state_hist
module tb_mpmc10_state_hist;

  localparam int W = 4, DEPTH = 4, CW = 8, TIMEOUT = 8, TCW = 16;
`ifdef MPMC10_STATE_HIST_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst = 1'b1;
  logic [W-1:0]       state = '0;
  logic               clr_timeout = 1'b0;
  logic [W-1:0]       prev_state, cur_state, timeout_state;
  logic [DEPTH*W-1:0] hist;
  logic               changed, timeout;
  logic [CW-1:0]      dwell;
  logic [TCW-1:0]     trans_cnt;

  mpmc10_state_hist #(.W(W), .DEPTH(DEPTH), .IDLE_CODE(0), .CW(CW),
                      .TIMEOUT(TIMEOUT), .TCW(TCW)) dut (
    .clk(clk), .rst(rst), .state(state), .clr_timeout(clr_timeout),
    .prev_state(prev_state), .cur_state(cur_state), .hist(hist),
    .changed(changed), .dwell(dwell), .trans_cnt(trans_cnt),
    .timeout(timeout), .timeout_state(timeout_state)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: history as a newest-first list, counters as plain integers.
  int m_prev, m_cur, m_dwell, m_trans, m_tos;
  bit m_changed, m_to, mv = 1'b0;
  int m_hist[$];

  always @(posedge clk) begin
    if (rst) begin
      m_prev = 0; m_cur = 0; m_dwell = 0; m_trans = 0; m_tos = 0;
      m_changed = 0; m_to = 0;
      m_hist = {0, 0, 0, 0};
      mv = 1'b1;
    end else begin
      int s;
      bit moved;
      s = int'(state);
      moved = (s != m_cur);
      if (TO_EN) begin
        if (m_cur != 0 && !moved && m_dwell == TIMEOUT - 1) begin
          if (!m_to || clr_timeout) m_tos = m_cur;
          m_to = 1;
        end else if (clr_timeout) begin
          m_to = 0;
        end
      end
      if (s == 0) m_prev = 0;
      else if (s != m_prev) m_prev = s;
      if (moved) begin
        m_hist.push_front(m_cur);
        void'(m_hist.pop_back());
        m_changed = 1;
        m_trans = (m_trans + 1) % (1 << TCW);
        m_dwell = 0;
      end else begin
        m_changed = 0;
        m_dwell = (s == 0) ? 0 : ((m_dwell + 1 > 255) ? 255 : m_dwell + 1);
      end
      m_cur = s;
    end
  end

  always @(negedge clk) begin
    if (mv) begin
      logic [DEPTH*W-1:0] eh;
      for (int i = 0; i < DEPTH; i++) eh[i*W +: W] = W'(m_hist[i]);
      check("cur_state", cur_state, m_cur);
      check("prev_state", prev_state, m_prev);
      check("hist", hist, eh);
      check("changed", changed, m_changed);
      check("dwell", dwell, m_dwell);
      check("trans_cnt", trans_cnt, m_trans);
      check("timeout", timeout, m_to);
      check("timeout_state", timeout_state, m_tos);
    end
  end

  task automatic cyc(input int s, input bit r = 1'b0, input bit c = 1'b0);
    state = W'(s); rst = r; clr_timeout = c;
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input int s, input int n);
    for (int i = 0; i < n; i++) cyc(s);
  endtask

  initial begin
    int nchg;
    // Reset with state=5 asserted
    cyc(5, 1); cyc(5, 1);
    check("rst_cur", cur_state, 0);
    check("rst_prev", prev_state, 0);
    check("rst_hist", hist, 16'h0000);
    check("rst_trans", trans_cnt, 0);
    check("rst_dwell", dwell, 0);
    check("rst_changed", changed, 0);
    cyc(5);
    check("post_rst_cur", cur_state, 5);
    check("post_rst_prev", prev_state, 5);
    check("post_rst_changed", changed, 1);
    check("post_rst_trans", trans_cnt, 1);

    // 0->1->2->3->4->5
    cyc(0, 1); cyc(0);
    nchg = 0;
    for (int s = 1; s <= 5; s++) begin
      cyc(s);
      nchg += int'(changed);
    end
    check("seq_hist", hist, 16'h1234);
    check("seq_trans", trans_cnt, 5);
    check("seq_changed_cycles", nchg, 5);
    cyc(5);
    check("seq_changed_drop", changed, 0);

    // Legacy previous-state rule
    cyc(0, 1);
    cyc(0); check("leg0", prev_state, 0);
    cyc(3); check("leg1", prev_state, 3);
    cyc(3); check("leg2", prev_state, 3);
    cyc(0); check("leg3", prev_state, 0);
    cyc(3); check("leg4", prev_state, 3);

    // Watchdog trip on a held state
    cyc(0, 1);
    hold(6, 8);
    check("wd_pre_trip", timeout, 0);
    check("wd_pre_dwell", dwell, 7);
    cyc(6);
    check("wd_trip", timeout, TO_EN);
    check("wd_trip_state", timeout_state, TO_EN ? 6 : 0);
    hold(6, 11);
    check("wd_dwell20", dwell, 19);
    cyc(6, 0, 1);
    check("wd_clear", timeout, 0);
    hold(6, 5);
    check("wd_no_reset", timeout, 0);
    cyc(2);
    check("wd_new_dwell", dwell, 0);

    // Idle exemption, then set-wins with recapture
    hold(0, 300);
    check("idle_dwell", dwell, 0);
    check("idle_timeout", timeout, 0);
    hold(7, 8);
    cyc(7, 0, 1);
    check("setwin_to", timeout, TO_EN);
    check("setwin_state", timeout_state, TO_EN ? 7 : 0);
    hold(9, 12);
    check("frozen_state", timeout_state, TO_EN ? 7 : 0);
    hold(5, 8);
    cyc(5, 0, 1);
    check("recapture_to", timeout, TO_EN);
    check("recapture_state", timeout_state, TO_EN ? 5 : 0);
    cyc(5, 0, 1);
    check("clear_again", timeout, 0);

    // Transition counter wrap, dwell saturation
    while (m_trans != 65535) cyc((m_cur == 1) ? 2 : 1);
    check("trans_max", trans_cnt, 16'hFFFF);
    cyc(9);
    check("trans_wrap", trans_cnt, 0);
    hold(9, 299);
    check("dwell_sat", dwell, 255);

    // Mid-run reset
    cyc(9, 1);
    check("midrst_cur", cur_state, 0);
    check("midrst_dwell", dwell, 0);
    check("midrst_timeout", timeout, 0);
    check("midrst_hist", hist, 16'h0000);

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mpmc10_state_hist.md
# mpmc10_state_hist

Parametrised state-history tracker for the mpmc10 controller FSM, replacing the single-entry previous-state register. It sits beside the controller state machine, samples its state every clock, and keeps the following:
- a legacy-compatible previous-state output;
- a DEPTH-entry transition history;
- a saturating dwell counter;
- a transition counter;
- an optional stuck-state watchdog.

All outputs are debug and sequencing aids; nothing feeds back into the controller combinationally.

## Interface
- W, 4, state code width in bits
- DEPTH, 4, history entries (≥1)
- IDLE_CODE, 0, state code treated as idle
- CW, 8, dwell counter width
- TIMEOUT, 200, dwell count that trips the watchdog (1 ≤ TIMEOUT ≤ 2^CW−1)
- TCW, 16, transition counter width

- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- state  in  W  current controller state
- clr_timeout  in  1  clears sticky timeout flag
- prev_state  out  W  legacy previous-state
- cur_state  out  W  registered copy of state
- hist  out  DEPTH*W  history, entry i at bits [i*W +: W], entry 0 newest
- changed  out  1  one-cycle pulse on transition
- dwell  out  CW  cycles in current state, saturating
- trans_cnt  out  TCW  transition count, wraps
- timeout  out  1  sticky watchdog flag
- timeout_state  out  W  state captured when watchdog tripped

## Operation
- Reset values, in the cycle after rst is high:
  - prev_state, cur_state and every hist entry = IDLE_CODE.
  - changed, dwell, trans_cnt, timeout = 0.
  - timeout_state = IDLE_CODE.
- rst overrides every other input.
- prev_state keeps the legacy rule exactly:
  - if state==IDLE_CODE, then prev_state ← IDLE_CODE;
  - else, if state≠prev_state, then prev_state ← state;
  - otherwise prev_state holds.
- cur_state ← state every cycle.
- A transition is the condition state≠cur_state. In that cycle:
  - hist[0] ← cur_state, and hist[i] ← hist[i−1] for i ≥ 1; the oldest entry is discarded.
  - changed ← 1. In every other cycle changed ← 0.
  - trans_cnt ← trans_cnt+1, modulo 2^TCW.
  - dwell ← 0.
- No transition:
  - hist holds.
  - If state==IDLE_CODE, dwell ← 0. Idle is exempt and the controller may stay idle indefinitely.
  - Otherwise dwell ← dwell+1, saturating at 2^CW−1.
- Watchdog (present only when compiled in):
  - Set condition: cur_state≠IDLE_CODE, no transition this cycle, and dwell==TIMEOUT−1.
  - On set: timeout ← 1 and timeout_state ← cur_state.
  - While timeout=1, timeout_state does not update.
  - clr_timeout=1 clears timeout.
  - If set and clear occur in the same cycle, set wins and timeout_state is recaptured.
- A state that changes every cycle fills the history at one entry per cycle. The history has no overflow condition; the oldest entry is simply lost.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- state sampled at edge t:
  - appears on cur_state and prev_state after edge t.
  - appears in hist[0] after the edge on which state next differs.
- changed is high for exactly one cycle, aligned with the hist and trans_cnt update.
- dwell equals N while cur_state has been held for N+1 consecutive samples (non-idle, unsaturated).
- timeout rises on the edge at which dwell would reach TIMEOUT.
- Reset asserted mid-run: all outputs return to their reset values on the next edge, regardless of state.

## Configuration
- MPMC10_STATE_HIST_TIMEOUT_EN defined: watchdog logic is present as specified under Operation.
- MPMC10_STATE_HIST_TIMEOUT_EN undefined:
  - timeout is tied to 0 and timeout_state to IDLE_CODE.
  - clr_timeout is ignored.
  - No watchdog logic is synthesised.
  - dwell, hist and trans_cnt are unaffected.

## Test plan
All scenarios use W=4, IDLE_CODE=0, DEPTH=4, CW=8, TIMEOUT=8, TCW=16, with the watchdog macro defined.
- Reset: hold rst 2 cycles while state=5 → all outputs at reset values; 1 cycle after rst falls, cur_state=5, prev_state=5, changed=1, trans_cnt=1.
- Sequence 0→1→2→3→4→5, one cycle each → hist = {4,3,2,1} (entry 0 first), trans_cnt=5, changed high for 5 consecutive cycles.
- Legacy rule: 0→3→3→0→3 → prev_state follows 0,3,3,0,3 cycle for cycle.
- Watchdog:
  - state=6 held 20 cycles → timeout rises when dwell would reach 8, timeout_state=6, dwell saturates only at 255.
  - Pulse clr_timeout with state still held at 6 → timeout clears and does not re-set.
  - state→2 → dwell=0.
- Idle exemption and set-wins: state=0 held 300 cycles → dwell=0, timeout=0; then state=7 for 8 cycles with clr_timeout held high on the trip cycle → timeout=1, timeout_state=7.
- Wrap and saturation: preload trans_cnt to 16'hFFFF via 65535 toggles (or force) → next transition gives trans_cnt=0; state=9 held 300 cycles gives dwell=255.
